// File: rtl/vend_coin_feeder.sv
// Coin feeder for a fixed-price (20 unit) vending item: issues nickels/dimes one per
// two cycles, checks the machine's dispense/change response and reports done or error.
module vend_coin_feeder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       prefer_nickel,
   input  logic [3:0] nickels_avail,
   input  logic [3:0] dimes_avail,
   input  logic       abort,
   output logic [1:0] coin,
   input  logic       dispense,
   input  logic       chg5,
   output logic       busy,
   output logic       done,
   output logic       got_change,
   output logic       err,
   output logic [1:0] err_code,
   output logic [2:0] coins_used
);

   typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP, S_DONE, S_ERR} state_t;

   localparam logic [1:0] C_NONE   = 2'b00;
   localparam logic [1:0] C_NICKEL = 2'b01;
   localparam logic [1:0] C_DIME   = 2'b10;

   localparam logic [1:0] E_NONE     = 2'b00;
   localparam logic [1:0] E_EXHAUST  = 2'b01;
   localparam logic [1:0] E_NODISP   = 2'b10;
   localparam logic [1:0] E_PROTOCOL = 2'b11;

   // Price and paid amount are counted in 5-unit steps.
   localparam logic [2:0] PRICE_STEPS = 3'd4;
   localparam logic [2:0] OVER_STEPS  = 3'd5;

   state_t     state_q;
   logic [1:0] coin_q;
   logic       done_q;
   logic       err_q;
   logic       got_q;
   logic [1:0] code_q;
   logic [2:0] used_q;
   logic [2:0] paid_q;
   logic [3:0] nick_q;
   logic [3:0] dime_q;
   logic       pref_q;

   logic [2:0] paid_d;
   logic [3:0] nick_d;
   logic [3:0] dime_d;
   logic [2:0] used_d;
   logic [1:0] first_coin_d;
   logic [1:0] next_coin_d;

   function automatic logic [1:0] pick_coin(input logic pref, input logic [3:0] n,
                                            input logic [3:0] d);
      logic [1:0] c;
      c = C_NONE;
      if (pref) begin
         if (n != 4'd0)      c = C_NICKEL;
         else if (d != 4'd0) c = C_DIME;
      end else begin
         if (d != 4'd0)      c = C_DIME;
         else if (n != 4'd0) c = C_NICKEL;
      end
      return c;
   endfunction

   always_comb begin
      paid_d       = paid_q + ((coin_q == C_DIME) ? 3'd2 : 3'd1);
      nick_d       = (coin_q == C_NICKEL) ? nick_q - 4'd1 : nick_q;
      dime_d       = (coin_q == C_DIME)   ? dime_q - 4'd1 : dime_q;
      used_d       = used_q + 3'd1;
      first_coin_d = pick_coin(prefer_nickel, nickels_avail, dimes_avail);
      next_coin_d  = pick_coin(pref_q, nick_q, dime_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         coin_q  <= C_NONE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         got_q   <= 1'b0;
         code_q  <= E_NONE;
         used_q  <= 3'd0;
         paid_q  <= 3'd0;
         nick_q  <= 4'd0;
         dime_q  <= 4'd0;
         pref_q  <= 1'b0;
      end else begin
         coin_q <= C_NONE;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  pref_q <= prefer_nickel;
                  nick_q <= nickels_avail;
                  dime_q <= dimes_avail;
                  paid_q <= 3'd0;
                  used_q <= 3'd0;
                  got_q  <= 1'b0;
                  code_q <= E_NONE;
                  if (first_coin_d != C_NONE) begin
                     coin_q  <= first_coin_d;
                     state_q <= S_COIN;
                  end else begin
                     err_q   <= 1'b1;
                     code_q  <= E_EXHAUST;
                     state_q <= S_ERR;
                  end
               end
            end
            S_COIN: begin
               // The coin on the bus this cycle is always booked, even when aborting.
               nick_q <= nick_d;
               dime_q <= dime_d;
               paid_q <= paid_d;
               used_q <= used_d;
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (paid_d < PRICE_STEPS) begin
                  if (dispense || chg5) begin
                     err_q   <= 1'b1;
                     code_q  <= E_PROTOCOL;
                     state_q <= S_ERR;
                  end else begin
                     state_q <= S_GAP;
                  end
               end else if (!dispense) begin
                  err_q   <= 1'b1;
                  code_q  <= E_NODISP;
                  state_q <= S_ERR;
               end else if (chg5 != (paid_d == OVER_STEPS)) begin
                  err_q   <= 1'b1;
                  code_q  <= E_PROTOCOL;
                  state_q <= S_ERR;
               end else begin
                  done_q  <= 1'b1;
                  got_q   <= chg5;
                  state_q <= S_DONE;
               end
            end
            S_GAP: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (next_coin_d != C_NONE) begin
                  coin_q  <= next_coin_d;
                  state_q <= S_COIN;
               end else begin
                  err_q   <= 1'b1;
                  code_q  <= E_EXHAUST;
                  state_q <= S_ERR;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign coin       = coin_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign got_change = got_q;
   assign err_code   = code_q;
   assign coins_used = used_q;

endmodule

// File: tb/tb_vend_coin_feeder.sv
// Bench for vend_coin_feeder: directed vector table, hand-written abort/reset
// sequences, and randomized transactions checked against a payment-rule model.
module tb_vend_coin_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       prefer_nickel;
   logic [3:0] nickels_avail;
   logic [3:0] dimes_avail;
   logic       abort;
   logic [1:0] coin;
   logic       dispense;
   logic       chg5;
   logic       busy;
   logic       done;
   logic       got_change;
   logic       err;
   logic [1:0] err_code;
   logic [2:0] coins_used;

   always #5 clk = ~clk;

   vend_coin_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .prefer_nickel(prefer_nickel),
      .nickels_avail(nickels_avail), .dimes_avail(dimes_avail), .abort(abort),
      .coin(coin), .dispense(dispense), .chg5(chg5), .busy(busy), .done(done),
      .got_change(got_change), .err(err), .err_code(err_code), .coins_used(coins_used)
   );

   // Vending-machine behaviours the bench can emulate.
   localparam int M_OK     = 0;
   localparam int M_HOLD   = 1;
   localparam int M_EARLY  = 2;
   localparam int M_BADCHG = 3;

   typedef struct {
      bit    pref;
      int    n;
      int    d;
      int    mode;
      string tr;
      bit    dn;
      int    code;
      bit    got;
      int    used;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outcome from the payment rules: 20 units, pick by preference, one gap per coin.
   function automatic void model(input bit pref, input int n, input int d, input int mode,
                                 output string tr, output bit dn, output int code,
                                 output bit got, output int used);
      int paid, nn, dd, val;
      paid = 0; nn = n; dd = d; used = 0; tr = ""; dn = 0; code = 1; got = 0;
      forever begin
         if (pref ? (nn > 0) : (dd == 0 && nn > 0)) begin
            val = 5; nn--; tr = {tr, "N"};
         end else if (dd > 0) begin
            val = 10; dd--; tr = {tr, "D"};
         end else begin
            code = 1;
            break;
         end
         used++;
         paid += val;
         if (mode == M_EARLY && used == 1) begin code = 3; break; end
         if (paid >= 20) begin
            if (mode == M_OK)        begin dn = 1; code = 0; got = (paid == 25); end
            else if (mode == M_HOLD) code = 2;
            else                     code = 3;
            break;
         end
         tr = {tr, "-"};
      end
   endfunction

   task automatic run_txn(input bit pref, input int n, input int d, input int mode,
                          output string tr, output bit dn, output bit er, output int code,
                          output bit got, output int used, output bit idle_ok,
                          output bit busy_ok, output bit term);
      int paid, k;
      paid = 0; k = 0; tr = ""; dn = 0; er = 0; code = 0; got = 0; used = 0;
      idle_ok = 0; busy_ok = 1; term = 0;
      start = 1'b1; prefer_nickel = pref; nickels_avail = n[3:0]; dimes_avail = d[3:0];
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 40 && !term; cyc++) begin
         dispense = 1'b0; chg5 = 1'b0;
         if (done || err) begin
            term = 1; dn = done; er = err;
         end else begin
            if (!busy) busy_ok = 0;
            case (coin)
               2'b01:   begin tr = {tr, "N"}; paid += 5;  k++; end
               2'b10:   begin tr = {tr, "D"}; paid += 10; k++; end
               2'b00:   tr = {tr, "-"};
               default: tr = {tr, "X"};
            endcase
            if (coin != 2'b00) begin
               if (mode == M_EARLY && k == 1) dispense = 1'b1;
               else if (paid >= 20 && mode != M_HOLD) begin
                  dispense = 1'b1;
                  chg5 = (mode == M_BADCHG) ? (paid != 25) : (paid == 25);
               end
            end
            tick();
         end
      end
      dispense = 1'b0; chg5 = 1'b0;
      tick();
      idle_ok = !busy && coin == 2'b00 && !done && !err;
      got = got_change; code = err_code; used = coins_used;
   endtask

   task automatic do_txn(input string tag, input bit pref, input int n, input int d,
                         input int mode, input string etr, input bit edn, input int ecode,
                         input bit egot, input int eused);
      string tr;
      bit dn, er, got, idle_ok, busy_ok, term;
      int code, used;
      run_txn(pref, n, d, mode, tr, dn, er, code, got, used, idle_ok, busy_ok, term);
      chk({tag, ".terminated"}, term, 1);
      chk_s({tag, ".coins"}, tr, etr);
      chk({tag, ".done"}, dn, edn);
      chk({tag, ".err"}, er, !edn);
      chk({tag, ".err_code"}, code, ecode);
      chk({tag, ".got_change"}, got, egot);
      chk({tag, ".coins_used"}, used, eused);
      chk({tag, ".busy"}, busy_ok, 1);
      chk({tag, ".idle_after"}, idle_ok, 1);
   endtask

   initial begin
      string etr;
      bit    edn, egot;
      int    ecode, eused, pref, n, d, mode, r;

      rst_n = 1'b0; start = 1'b0; prefer_nickel = 1'b0; nickels_avail = 4'd0;
      dimes_avail = 4'd0; abort = 1'b0; dispense = 1'b0; chg5 = 1'b0;

      vecs.push_back('{0, 0, 2, M_OK,     "D-D",     1, 0, 0, 2});
      vecs.push_back('{1, 2, 1, M_OK,     "N-N-D",   1, 0, 0, 3});
      vecs.push_back('{1, 1, 2, M_OK,     "N-D-D",   1, 0, 1, 3});
      vecs.push_back('{0, 1, 1, M_OK,     "D-N-",    0, 1, 0, 2});
      vecs.push_back('{0, 0, 2, M_HOLD,   "D-D",     0, 2, 0, 2});
      vecs.push_back('{0, 0, 2, M_EARLY,  "D",       0, 3, 0, 1});
      vecs.push_back('{0, 0, 0, M_OK,     "",        0, 1, 0, 0});
      vecs.push_back('{0, 1, 2, M_BADCHG, "D-D",     0, 3, 0, 2});
      vecs.push_back('{1, 4, 0, M_OK,     "N-N-N-N", 1, 0, 0, 4});
      vecs.push_back('{0, 3, 1, M_OK,     "D-N-N",   1, 0, 0, 3});

      repeat (3) tick();
      chk("reset.coin", coin, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.err", err, 0);
      chk("reset.got_change", got_change, 0);
      chk("reset.err_code", err_code, 0);
      chk("reset.coins_used", coins_used, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++)
         do_txn($sformatf("vec%0d", i), vecs[i].pref, vecs[i].n, vecs[i].d, vecs[i].mode,
                vecs[i].tr, vecs[i].dn, vecs[i].code, vecs[i].got, vecs[i].used);

      // Abort while a coin is on the bus: the coin is booked, no pulse follows.
      start = 1'b1; prefer_nickel = 1'b0; nickels_avail = 4'd0; dimes_avail = 4'd2;
      tick();
      start = 1'b0;
      chk("abort_coin.coin", coin, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_coin.busy", busy, 0);
      chk("abort_coin.coin_after", coin, 0);
      chk("abort_coin.no_pulse", done | err, 0);
      chk("abort_coin.coins_used", coins_used, 1);
      tick();
      chk("abort_coin.stays_idle", {busy, done, err, coin}, 0);

      // Abort during the gap, with a stray start that must be ignored.
      start = 1'b1; prefer_nickel = 1'b1; nickels_avail = 4'd3; dimes_avail = 4'd0;
      tick();
      start = 1'b0;
      tick();
      chk("abort_gap.gap_coin", coin, 0);
      chk("abort_gap.gap_busy", busy, 1);
      abort = 1'b1; start = 1'b1; nickels_avail = 4'd0;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_gap.busy", busy, 0);
      chk("abort_gap.no_pulse", done | err, 0);
      chk("abort_gap.coins_used", coins_used, 1);
      tick();

      // Abort ignored in IDLE; next start still works.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      do_txn("after_abort", 0, 0, 2, M_OK, "D-D", 1, 0, 0, 2);

      // Reset asserted mid-coin takes effect immediately.
      start = 1'b1; prefer_nickel = 1'b0; nickels_avail = 4'd0; dimes_avail = 4'd2;
      tick();
      start = 1'b0;
      chk("rst_coin.before", coin, 2);
      rst_n = 1'b0;
      #1;
      chk("rst_coin.coin", coin, 0);
      chk("rst_coin.busy", busy, 0);
      #2 rst_n = 1'b1;
      tick();

      // Reset during a gap, then a fresh transaction pays from zero.
      start = 1'b1; prefer_nickel = 1'b0; nickels_avail = 4'd0; dimes_avail = 4'd2;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_gap.coin", coin, 0);
      chk("rst_gap.busy", busy, 0);
      chk("rst_gap.coins_used", coins_used, 0);
      #2 rst_n = 1'b1;
      tick();
      do_txn("after_rst", 0, 0, 2, M_OK, "D-D", 1, 0, 0, 2);

      for (int t = 0; t < 40; t++) begin
         pref = $urandom_range(0, 1);
         n    = $urandom_range(0, 4);
         d    = $urandom_range(0, 3);
         r    = $urandom_range(0, 9);
         mode = (r < 7) ? M_OK : (r - 6);
         model(pref[0], n, d, mode, etr, edn, ecode, egot, eused);
         do_txn($sformatf("rnd%0d", t), pref[0], n, d, mode, etr, edn, ecode, egot, eused);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vend_coin_feeder.md
VEND_COIN_FEEDER -- requirements
Module: vend_coin_feeder

Interface
REQ-001 The block SHALL have these ports, in this order:
  clk             input   1  single clock; all state changes on posedge.
  rst_n           input   1  reset; asynchronous, active-low.
  start           input   1  one-cycle request to pay for one item; honoured only in IDLE.
  prefer_nickel   input   1  coin-selection mode, sampled with start.
  nickels_avail   input   4  nickels available, sampled with start.
  dimes_avail     input   4  dimes available, sampled with start.
  abort           input   1  cancel an in-progress payment.
  coin            output  2  coin bus to the vending machine: 00 none, 01 nickel (5), 10 dime (10); 11 is never driven.
  dispense        input   1  vending machine vend indication (Mealy; valid in the same cycle as the completing coin).
  chg5            input   1  vending machine 5-unit change indication (same timing as dispense).
  busy            output  1  high whenever the state is not IDLE.
  done            output  1  one-cycle pulse: vend completed correctly.
  got_change      output  1  chg5 value captured at the completing coin; held until the next accepted start.
  err             output  1  one-cycle pulse: payment failed.
  err_code        output  2  00 none, 01 coins exhausted, 10 no dispense, 11 protocol mismatch; held until the next accepted start.
  coins_used      output  3  number of coins issued for the current transaction.
REQ-002 Item price SHALL be the fixed constant 20 units.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, COIN, GAP, DONE, ERR.
REQ-004 IDLE with start=1 SHALL:
  - latch prefer_nickel, nickels_avail and dimes_avail into internal counters;
  - clear paid, coins_used, got_change and err_code;
  - make the coin decision (REQ-005), so that the first coin appears on coin in the cycle immediately after start.
REQ-005 Coin decision:
  - prefer_nickel=0: use a dime if the dime count is > 0, otherwise a nickel if the nickel count is > 0.
  - prefer_nickel=1: use a nickel if the nickel count is > 0, otherwise a dime.
  - If no coin is available, go to ERR with err_code=01.
REQ-006 COIN SHALL drive the selected coin code for exactly one cycle, then:
  - decrement the used coin counter;
  - increment coins_used;
  - add the coin value to paid.
  Paid is tracked in 5-unit steps in a 3-bit register, with range 0..5.
REQ-007 GAP SHALL follow every COIN, drive coin=00 for exactly one cycle, then make the next coin decision.
REQ-008 At the end of a COIN cycle whose updated paid is < 20:
  - dispense=1 or chg5=1 SHALL go to ERR with err_code=11;
  - otherwise go to GAP.
REQ-009 At the end of a COIN cycle whose updated paid is >= 20:
  - dispense=0 SHALL go to ERR with err_code=10;
  - dispense=1 with chg5 different from (paid==25) SHALL go to ERR with err_code=11;
  - otherwise go to DONE and capture got_change=chg5.
REQ-010 DONE and ERR SHALL each last one cycle:
  - DONE asserts done; ERR asserts err;
  - coin=00 in both;
  - both return to IDLE.
REQ-011 abort=1 in COIN or GAP SHALL return to IDLE at the next edge:
  - no done or err pulse;
  - any coin in flight in that cycle is still completed as driven;
  - abort in IDLE, DONE or ERR SHALL be ignored.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 dispense and chg5 SHALL be ignored in IDLE, GAP, DONE and ERR.
REQ-014 coin, done and err SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-015 rst_n=0 SHALL immediately force:
  - state=IDLE, coin=00, busy=0, done=0, err=0;
  - got_change=0, err_code=00, coins_used=0;
  - all internal counters and paid to 0.
  This applies in any state, including mid-coin.
REQ-016 After rst_n deasserts, the first start SHALL be accepted on the first posedge with start=1.

Verification
REQ-017 Dime-pref, dimes=2, nickels=0; start at cycle k:
  - coin=10 at k+1, 00 at k+2, 10 at k+3 with dispense=1, chg5=0;
  - done=1 at k+4; got_change=0; coins_used=2.
REQ-018 Nickel-pref, nickels=2, dimes=1:
  - coin sequence 01, 00, 01, 00, 10;
  - dispense at the third coin; done; got_change=0; coins_used=3.
REQ-019 Nickel-pref, nickels=1, dimes=2:
  - coin sequence 01, 00, 10, 00, 10 (paid 25);
  - model asserts dispense=1, chg5=1; done; got_change=1.
REQ-020 Dime-pref, dimes=1, nickels=1:
  - coin sequence 10, 00, 01, 00;
  - then err=1 with err_code=01, coins_used=2, coin stays 00.
REQ-021 Model withholds dispense at the completing coin -> err_code=10. Model asserts dispense at the first coin -> err_code=11.
REQ-022 rst_n pulsed low during a GAP -> coin=00 and busy=0 immediately; a subsequent start pays from zero.
